// File: rtl/dpram_arb_pkg.sv
// Shared definitions for the dual-master RAM port-B arbiter: master IDs and byte-mask width.
package dpram_arb_pkg;

    localparam int unsigned WEM_W = 4;

    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_id_e;

    // Byte strobes only reach the RAM on writes.
    function automatic logic [WEM_W-1:0] eff_wem(input logic we, input logic [WEM_W-1:0] wem);
        return we ? wem : WEM_W'(0);
    endfunction

endpackage

// File: rtl/dpram_arb_if.sv
// Bundle of both master request/response ports and the RAM port-B connection.
interface dpram_arb_if
    import dpram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
);
    logic              m0_req,    m1_req;
    logic              m0_we,     m1_we;
    logic [WEM_W-1:0]  m0_wem,    m1_wem;
    logic [ADDR_W-1:0] m0_addr,   m1_addr;
    logic [DATA_W-1:0] m0_wdata,  m1_wdata;
    logic              m0_gnt,    m1_gnt;
    logic              m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata,  m1_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [WEM_W-1:0]  ram_wem;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    // Arbiter view
    modport slave (
        input  m0_req, m0_we, m0_wem, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_wem, m1_addr, m1_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_en, ram_we, ram_wem, ram_addr, ram_din,
        input  ram_dout
    );

    // Requesting masters' view
    modport master (
        output m0_req, m0_we, m0_wem, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_wem, m1_addr, m1_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata
    );

    // RAM port-B view
    modport ram (
        input  ram_en, ram_we, ram_wem, ram_addr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/dpram_arb_rr.sv
// Two-way round-robin selector: on conflict grant the favoured master, then favour the loser.
module dpram_arb_rr
    import dpram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    arb_id_e rr_ptr_q, rr_ptr_d;

    // Grant selection and pointer advance; uncontested grants leave the pointer alone
    always_comb begin
        gnt_o    = req_i;
        rr_ptr_d = rr_ptr_q;
        if (&req_i) begin
            if (rr_ptr_q == ARB_M0) begin
                gnt_o    = 2'b01;
                rr_ptr_d = ARB_M1;
            end else begin
                gnt_o    = 2'b10;
                rr_ptr_d = ARB_M0;
            end
        end
    end

    // Pointer register, m0 favoured out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= ARB_M0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
endmodule

// File: rtl/dpram_arb.sv
// Arbiter sharing RAM port B between core LSU (m0) and debug/loader (m1).
// Combinational grant, one-cycle read response routed back to the granted master.
// Define DPRAM_ARB_RR_EN for round-robin conflict resolution; otherwise m0 has fixed priority.
module dpram_arb
    import dpram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
) (
    input logic        clk,
    input logic        rst_n,
    dpram_arb_if.slave bus
);
    logic [1:0]        req_c;
    logic [1:0]        gnt_c;
    logic              en_c;
    logic              we_c;
    logic [WEM_W-1:0]  wem_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] din_c;
    logic              rv0_c, rv1_c;

    logic              resp_pend_q, resp_pend_d;
    arb_id_e           resp_id_q,   resp_id_d;

    // Requests are masked while in reset so no grant or RAM access can escape
    assign req_c = {bus.m1_req & rst_n, bus.m0_req & rst_n};

`ifdef DPRAM_ARB_RR_EN
    dpram_arb_rr u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req_c),
        .gnt_o (gnt_c)
    );
`else
    // Fixed priority: m0 wins any conflict
    assign gnt_c = {req_c[1] & ~req_c[0], req_c[0]};
`endif

    // RAM port-B drive from the winner, all-zero when idle
    always_comb begin
        en_c   = 1'b0;
        we_c   = 1'b0;
        wem_c  = '0;
        addr_c = '0;
        din_c  = '0;
        if (gnt_c[1]) begin
            en_c   = 1'b1;
            we_c   = bus.m1_we;
            wem_c  = eff_wem(bus.m1_we, bus.m1_wem);
            addr_c = bus.m1_addr;
            din_c  = bus.m1_wdata;
        end else if (gnt_c[0]) begin
            en_c   = 1'b1;
            we_c   = bus.m0_we;
            wem_c  = eff_wem(bus.m0_we, bus.m0_wem);
            addr_c = bus.m0_addr;
            din_c  = bus.m0_wdata;
        end
    end

    // Granted reads open a response slot for the next cycle; resp_id follows the newest read
    always_comb begin
        resp_pend_d = 1'b0;
        resp_id_d   = resp_id_q;
        if (en_c && !we_c) begin
            resp_pend_d = 1'b1;
            resp_id_d   = gnt_c[1] ? ARB_M1 : ARB_M0;
        end
    end

    // Response tracking registers; reset drops any pending response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_pend_q <= 1'b0;
            resp_id_q   <= ARB_M0;
        end else begin
            resp_pend_q <= resp_pend_d;
            resp_id_q   <= resp_id_d;
        end
    end

    assign rv0_c = resp_pend_q && (resp_id_q == ARB_M0);
    assign rv1_c = resp_pend_q && (resp_id_q == ARB_M1);

    assign bus.m0_gnt    = gnt_c[0];
    assign bus.m1_gnt    = gnt_c[1];
    assign bus.ram_en    = en_c;
    assign bus.ram_we    = we_c;
    assign bus.ram_wem   = wem_c;
    assign bus.ram_addr  = addr_c;
    assign bus.ram_din   = din_c;
    assign bus.m0_rvalid = rv0_c;
    assign bus.m1_rvalid = rv1_c;
    assign bus.m0_rdata  = rv0_c ? bus.ram_dout : '0;
    assign bus.m1_rdata  = rv1_c ? bus.ram_dout : '0;
endmodule

// File: tb/tb_dpram_arb.sv
// Bench for dpram_arb: behavioural RAM on port B plus a transaction-level reference model.
// Build with or without DPRAM_ARB_RR_EN; expectations follow the same macro.
module tb_dpram_arb;
    import dpram_arb_pkg::*;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2048;
    localparam int unsigned VW     = 117;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dpram_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dpram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] init_word(input int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hC3A5_0F96;
    endfunction

    // Synchronous RAM, read data one cycle after the access edge
    logic [31:0] env_mem [DEPTH];
    logic        env_done = 1'b0;
    always @(posedge clk) begin
        if (!env_done) begin
            for (int i = 0; i < int'(DEPTH); i++) env_mem[i] <= init_word(i);
            env_done <= 1'b1;
        end else if (bus.ram_en) begin
            if (bus.ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_wem[b]) env_mem[bus.ram_addr][8*b +: 8] <= bus.ram_din[8*b +: 8];
            end else begin
                bus.ram_dout <= env_mem[bus.ram_addr];
            end
        end
    end

    // Stimulus for the next cycle
    logic        d_rst_n;
    logic [1:0]  d_req, d_we;
    logic [3:0]  d_wem   [2];
    logic [10:0] d_addr  [2];
    logic [31:0] d_wdata [2];

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int          m_fav;
    logic        m_pend;
    int          m_pend_id;
    logic [31:0] m_pend_data;

    // Observed / expected for the last cycle
    logic [VW-1:0] obs_v, exp_v;
    logic [1:0]    obs_gnt, obs_rv, exp_gnt;
    logic          obs_en;
    logic [31:0]   obs_rd0, obs_rd1;

    int n_checks = 0;
    int n_err    = 0;

    // Apply one cycle of stimulus, sample outputs and advance the reference model
    task automatic tick();
        int          w;
        logic        e_en, e_we;
        logic [3:0]  e_wem;
        logic [10:0] e_addr;
        logic [31:0] e_din, e_rd0, e_rd1;
        logic [1:0]  e_rv;
        @(negedge clk);
        rst_n        = d_rst_n;
        bus.m0_req   = d_req[0];  bus.m1_req   = d_req[1];
        bus.m0_we    = d_we[0];   bus.m1_we    = d_we[1];
        bus.m0_wem   = d_wem[0];  bus.m1_wem   = d_wem[1];
        bus.m0_addr  = d_addr[0]; bus.m1_addr  = d_addr[1];
        bus.m0_wdata = d_wdata[0];bus.m1_wdata = d_wdata[1];
        #1;
        obs_gnt = {bus.m1_gnt, bus.m0_gnt};
        obs_rv  = {bus.m1_rvalid, bus.m0_rvalid};
        obs_en  = bus.ram_en;
        obs_rd0 = bus.m0_rdata;
        obs_rd1 = bus.m1_rdata;
        obs_v   = {bus.m1_gnt, bus.m0_gnt, bus.ram_en, bus.ram_we, bus.ram_wem, bus.ram_addr,
                   bus.ram_din, bus.m1_rvalid, bus.m0_rvalid, bus.m1_rdata, bus.m0_rdata};

        w = -1;
        if (!d_rst_n) begin
            m_pend = 1'b0;
            m_fav  = 0;
        end else if (d_req == 2'b11) begin
`ifdef DPRAM_ARB_RR_EN
            w = m_fav;
`else
            w = 0;
`endif
            m_fav = 1 - w;
        end else if (d_req[0]) begin
            w = 0;
        end else if (d_req[1]) begin
            w = 1;
        end

        e_rv  = 2'b00;
        e_rd0 = '0;
        e_rd1 = '0;
        if (m_pend) begin
            e_rv[m_pend_id] = 1'b1;
            if (m_pend_id == 0) e_rd0 = m_pend_data;
            else                e_rd1 = m_pend_data;
        end

        exp_gnt = 2'b00;
        e_en = 1'b0; e_we = 1'b0; e_wem = '0; e_addr = '0; e_din = '0;
        m_pend = 1'b0;
        if (w >= 0) begin
            exp_gnt[w] = 1'b1;
            e_en   = 1'b1;
            e_we   = d_we[w];
            e_wem  = d_we[w] ? d_wem[w] : 4'h0;
            e_addr = d_addr[w];
            e_din  = d_wdata[w];
            if (d_we[w]) begin
                for (int b = 0; b < 4; b++)
                    if (d_wem[w][b]) ref_mem[d_addr[w]][8*b +: 8] = d_wdata[w][8*b +: 8];
            end else begin
                m_pend      = 1'b1;
                m_pend_id   = w;
                m_pend_data = ref_mem[d_addr[w]];
            end
        end
        exp_v = {exp_gnt, e_en, e_we, e_wem, e_addr, e_din, e_rv, e_rd1, e_rd0};
    endtask

    task automatic set_idle();
        d_req = 2'b00; d_we = 2'b00;
        for (int m = 0; m < 2; m++) begin
            d_wem[m] = 4'h0; d_addr[m] = '0; d_wdata[m] = '0;
        end
    endtask

    task automatic set_read(input int m, input logic [10:0] a);
        d_req[m] = 1'b1; d_we[m] = 1'b0; d_addr[m] = a;
        d_wem[m] = 4'($urandom); d_wdata[m] = $urandom;
    endtask

    task automatic test_reset();
        d_rst_n = 1'b0;
        set_idle();
        set_read(0, 11'h005);
        set_read(1, 11'h006);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL reset cyc%0d: got %h want %h", c, obs_v, exp_v);
            end
            n_checks++;
            if (obs_gnt !== 2'b00 || obs_en !== 1'b0 || obs_rv !== 2'b00) begin
                n_err++;
                $display("FAIL reset_quiet cyc%0d: gnt=%b en=%b rv=%b want 00/0/00", c, obs_gnt, obs_en, obs_rv);
            end
        end
        d_rst_n = 1'b1;
        set_idle();
        tick();
        n_checks++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL reset_release: got %h want %h", obs_v, exp_v);
        end
    endtask

    task automatic test_conflict();
        logic [7:0] seq, want;
`ifdef DPRAM_ARB_RR_EN
        want = 8'b10_01_10_01;
`else
        want = 8'b01_01_01_01;
`endif
        seq = '0;
        for (int c = 0; c < 4; c++) begin
            set_read(0, 11'(8'h80 + c));
            set_read(1, 11'(8'hC0 + c));
            tick();
            seq[2*c +: 2] = obs_gnt;
            n_checks++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL conflict cyc%0d: got %h want %h", c, obs_v, exp_v);
            end
        end
        n_checks++;
        if (seq !== want) begin
            n_err++;
            $display("FAIL conflict_seq: got %b want %b", seq, want);
        end
        set_idle();
        tick();
        n_checks++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL conflict_drain: got %h want %h", obs_v, exp_v);
        end
    endtask

    task automatic test_single_read();
        set_idle();
        set_read(0, 11'h010);
        tick();
        n_checks++;
        if (obs_gnt !== 2'b01 || obs_v !== exp_v) begin
            n_err++;
            $display("FAIL single_gnt: got %h want %h", obs_v, exp_v);
        end
        set_idle();
        tick();
        n_checks++;
        if (obs_rv !== 2'b01 || obs_rd0 !== init_word(16) || obs_rd1 !== 32'h0) begin
            n_err++;
            $display("FAIL single_resp: rv=%b rd0=%h rd1=%h want 01 %h 0", obs_rv, obs_rd0, obs_rd1, init_word(16));
        end
    endtask

    task automatic test_write_read();
        logic [31:0] orig, want;
        orig = init_word(11'h7FF);
        want = {orig[31:16], 8'hCC, orig[7:0]};
        set_idle();
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_wem[1] = 4'b0010;
        d_addr[1] = 11'h7FF; d_wdata[1] = 32'hAABB_CCDD;
        tick();
        n_checks++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL wr_issue: got %h want %h", obs_v, exp_v);
        end
        set_idle();
        set_read(1, 11'h7FF);
        tick();
        n_checks++;
        if (obs_rv !== 2'b00 || obs_v !== exp_v) begin
            n_err++;
            $display("FAIL wr_no_rvalid: got %h want %h", obs_v, exp_v);
        end
        set_idle();
        tick();
        n_checks++;
        if (obs_rv !== 2'b10 || obs_rd1 !== want) begin
            n_err++;
            $display("FAIL wr_readback: rv=%b rd1=%h want 10 %h", obs_rv, obs_rd1, want);
        end
    endtask

    task automatic test_back_to_back();
        set_idle();
        set_read(0, 11'h040);
        tick();
        set_idle();
        set_read(1, 11'h041);
        tick();
        n_checks++;
        if (obs_rv !== 2'b01 || obs_rd0 !== init_word(11'h040) || obs_gnt !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_m0: rv=%b rd0=%h gnt=%b want 01 %h 10", obs_rv, obs_rd0, obs_gnt, init_word(11'h040));
        end
        set_idle();
        tick();
        n_checks++;
        if (obs_rv !== 2'b10 || obs_rd1 !== init_word(11'h041) || obs_rd0 !== 32'h0) begin
            n_err++;
            $display("FAIL b2b_m1: rv=%b rd1=%h rd0=%h want 10 %h 0", obs_rv, obs_rd1, obs_rd0, init_word(11'h041));
        end
    endtask

    task automatic test_random();
        logic [1:0] last_gnt;
        set_idle();
        last_gnt = 2'b00;
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!d_req[m] || last_gnt[m]) begin
                    d_req[m]   = ($urandom_range(0, 3) != 0);
                    d_we[m]    = 1'($urandom);
                    d_wem[m]   = 4'($urandom);
                    d_addr[m]  = 11'($urandom_range(0, 31));
                    d_wdata[m] = $urandom;
                end
            end
            tick();
            last_gnt = exp_gnt;
            n_checks++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL random cyc%0d: got %h want %h", c, obs_v, exp_v);
            end
        end
        set_idle();
        tick();
        n_checks++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL random_drain: got %h want %h", obs_v, exp_v);
        end
    endtask

    task automatic test_reset_pending();
        for (int k = 0; k < 2; k++) begin
            if (m_fav != 1) begin
                set_read(0, 11'h050);
                set_read(1, 11'h051);
                tick();
            end
        end
        set_idle();
        set_read(0, 11'h020);
        tick();
        n_checks++;
        if (obs_gnt !== 2'b01 || obs_v !== exp_v) begin
            n_err++;
            $display("FAIL rstp_issue: got %h want %h", obs_v, exp_v);
        end
        d_rst_n = 1'b0;
        set_read(0, 11'h021);
        set_read(1, 11'h022);
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (obs_gnt !== 2'b00 || obs_en !== 1'b0 || obs_rv !== 2'b00) begin
                n_err++;
                $display("FAIL rstp_hold cyc%0d: gnt=%b en=%b rv=%b want 00/0/00", c, obs_gnt, obs_en, obs_rv);
            end
        end
        d_rst_n = 1'b1;
        set_idle();
        tick();
        n_checks++;
        if (obs_rv !== 2'b00 || obs_v !== exp_v) begin
            n_err++;
            $display("FAIL rstp_release: got %h want %h", obs_v, exp_v);
        end
        set_read(0, 11'h023);
        set_read(1, 11'h024);
        tick();
        n_checks++;
        if (obs_gnt !== 2'b01 || obs_v !== exp_v) begin
            n_err++;
            $display("FAIL rstp_first_conflict: got %h want %h", obs_v, exp_v);
        end
        set_idle();
        tick();
        n_checks++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL rstp_drain: got %h want %h", obs_v, exp_v);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        d_rst_n = 1'b0;
        set_idle();
        m_fav       = 0;
        m_pend      = 1'b0;
        m_pend_id   = 0;
        m_pend_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);

        test_reset();
        test_conflict();
        test_single_read();
        test_write_read();
        test_back_to_back();
        test_random();
        test_reset_pending();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/dpram_arb.md
DPRAM_ARB -- requirements
Module: dpram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, giving the RAM word-address width (depth 2048).
REQ-002 SHALL have parameter DATA_W, default 32, giving the RAM data width; byte-mask width is DATA_W/8 (4).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports m0_req/m1_req, input, 1 bit each: the master requests a RAM access (m0 = core LSU, m1 = debug/loader).
REQ-006 SHALL have ports m0_we/m1_we (1), m0_wem/m1_wem (4) and m0_addr/m1_addr (ADDR_W), all inputs: write flag, byte strobes and word address.
REQ-007 SHALL have ports m0_wdata/m1_wdata, input, DATA_W: write data.
REQ-008 SHALL have ports m0_gnt/m1_gnt, output, 1 bit each: the request is accepted this cycle.
REQ-009 SHALL have ports m0_rvalid/m1_rvalid (output, 1) and m0_rdata/m1_rdata (output, DATA_W): read response.
REQ-010 SHALL have ports ram_en, ram_we (1), ram_wem (4), ram_addr (ADDR_W) and ram_din (DATA_W), all outputs: drive RAM port B.
REQ-011 SHALL have port ram_dout, input, DATA_W: RAM port B read data, valid one cycle after the read is issued.

Function
REQ-012 Grant SHALL be combinational, with at most one gnt high per cycle; gnt SHALL be high only when the matching req is high.
REQ-013 A master SHALL hold req, we, wem, addr and wdata stable until it sees gnt high; a new request may be presented in the cycle after gnt.
REQ-014 When one master requests, it SHALL be granted in the same cycle; back-to-back grants every cycle are allowed.
REQ-015 When both masters request, the winner SHALL be set by the arbitration policy (REQ-024/025).
REQ-016 On grant, ram_en=1 and ram_we/ram_wem/ram_addr/ram_din SHALL equal the winner's signals; with no grant, ram_en=0 and ram_we=0, and the other ram_* outputs SHALL be 0.
REQ-017 ram_wem SHALL be forced to 0 whenever ram_we=0.
REQ-018 A granted read SHALL register resp_pend=1 and resp_id=winner; in the next cycle, the rvalid of that master SHALL go high for exactly one cycle, with its rdata = ram_dout.
REQ-019 A granted write SHALL produce no rvalid; the write completes at the grant edge.
REQ-020 The non-responding master's rdata SHALL be 0 and its rvalid 0.
REQ-021 If a new read is granted in the same cycle as a pending response, both SHALL proceed in pipeline: the response goes to the old resp_id and resp_id updates to the new winner.

Reset
REQ-022 While rst_n=0, all gnt, rvalid and ram_en outputs SHALL be 0; resp_pend=0, resp_id=0 and rr_ptr=0.
REQ-023 Reset asserted while a read response is pending SHALL discard that response, and no rvalid SHALL follow reset release.

Configuration
REQ-024 With DPRAM_ARB_RR_EN defined, a round-robin pointer rr_ptr SHALL select the favoured master on conflict; after each conflict grant, rr_ptr SHALL point to the loser; uncontested grants SHALL NOT change rr_ptr; after reset, m0 is favoured first.
REQ-025 Without DPRAM_ARB_RR_EN, m0 SHALL always win a conflict (fixed priority), and no rr_ptr register SHALL exist.

Structure
REQ-026 Master-ID constants (ARB_M0=0, ARB_M1=1) and the byte-mask width SHALL live in the shared defines file.
REQ-027 The 2-way round-robin pointer and selection logic SHALL be one sub-module, dpram_arb_rr, instantiated only when DPRAM_ARB_RR_EN is defined.

Verification
REQ-028 m0 reads addr 0x010 alone -> m0_gnt=1 in cycle 0; m0_rvalid=1 in cycle 1 with m0_rdata=RAM[0x010]; m1 signals stay 0.
REQ-029 m1 writes addr 0x7FF, wem=4'b0010, wdata=0xAABBCCDD, then reads 0x7FF -> m1_rdata has byte1=0xCC and the other bytes unchanged; no rvalid for the write.
REQ-030 Both masters request reads continuously for 4 cycles -> with RR: grants m0,m1,m0,m1; without RR: m0,m0,m0,m0 with m1_gnt=0.
REQ-031 m0 read at cycle 0 and m1 read at cycle 1 back-to-back -> m0_rvalid at cycle 1 and m1_rvalid at cycle 2, each carrying its own address's data.
REQ-032 Read granted, then rst_n pulled low before the next edge -> no rvalid after release; ram_en=0 during reset; the first conflict after reset is won by m0.
